// File: rtl/kf_engine.sv
// Microcoded fixed-point engine: loadable program memory, NR-entry register file, signed ALU, streaming in/out.
// Optional KF_SAT_EN: saturate out-of-range ADD/SUB/MUL results and raise a sticky sat_flag.
module kf_engine #(
    parameter int unsigned W     = 24,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned NR    = 16,
    parameter int unsigned ADDRW = 4,
    parameter int unsigned PW    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [PW-1:0]         prog_waddr,
    input  logic [4+3*ADDRW-1:0]  prog_wdata,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    output logic [PW-1:0]         pc_dbg
);
    localparam int unsigned IW    = 4 + 3 * ADDRW;
    localparam int unsigned DEPTH = 2 ** PW;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_IN   = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MUL, S_IN_WAIT, S_OUT_WAIT} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pc_q, pc_d;
    logic [IW-1:0]       ir_q, ir_d;
    logic [W-1:0]        rf_q [NR];
    logic [W-1:0]        rf_d [NR];
    logic [2*W-1:0]      prod_q, prod_d;
    logic [W-1:0]        out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sat_q, sat_d;
    logic [IW-1:0]       mem_q [DEPTH];
    logic                mem_we_c;

    logic [3:0]          op;
    logic [ADDRW-1:0]    dst, src_a, src_b;
    logic [W-1:0]        a_val, b_val;
    logic [W:0]          sum_w;
    logic [2*W-1:0]      prod_full, shifted;
    logic [W-1:0]        add_res, mul_res;
    logic                add_ovf, mul_ovf;
    logic                we_c;
    logic [W-1:0]        wd_c;

    assign op    = ir_q[IW-1 -: 4];
    assign dst   = ir_q[3*ADDRW-1 -: ADDRW];
    assign src_a = ir_q[2*ADDRW-1 -: ADDRW];
    assign src_b = ir_q[ADDRW-1:0];

    // Register-file read: r0 and unimplemented addresses read as zero
    always_comb begin
        a_val = '0;
        b_val = '0;
        for (int unsigned i = 1; i < NR; i++) begin
            if (src_a == ADDRW'(i)) a_val = rf_q[i];
            if (src_b == ADDRW'(i)) b_val = rf_q[i];
        end
    end

    assign sum_w     = (op == OP_SUB) ? ({a_val[W-1], a_val} - {b_val[W-1], b_val})
                                      : ({a_val[W-1], a_val} + {b_val[W-1], b_val});
    assign prod_full = $signed({{W{a_val[W-1]}}, a_val}) * $signed({{W{b_val[W-1]}}, b_val});
    assign shifted   = $signed(prod_q) >>> FRAC;

`ifdef KF_SAT_EN
    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    assign add_ovf = sum_w[W] ^ sum_w[W-1];
    assign add_res = add_ovf ? (sum_w[W] ? S_MIN : S_MAX) : sum_w[W-1:0];
    assign mul_ovf = (|shifted[2*W-1:W-1]) && !(&shifted[2*W-1:W-1]);
    assign mul_res = mul_ovf ? (shifted[2*W-1] ? S_MIN : S_MAX) : shifted[W-1:0];
`else
    assign add_ovf = 1'b0;
    assign add_res = sum_w[W-1:0];
    assign mul_ovf = 1'b0;
    assign mul_res = shifted[W-1:0];
`endif

    // Sequencer: next state, writeback and handshake outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        prod_d      = prod_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        done_d      = 1'b0;
        sat_d       = sat_q;
        mem_we_c    = 1'b0;
        we_c        = 1'b0;
        wd_c        = '0;
        case (state_q)
            S_IDLE: begin
                mem_we_c = prog_we;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    sat_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        we_c    = 1'b1;
                        wd_c    = add_res;
                        sat_d   = sat_q | add_ovf;
                        pc_d    = pc_q + PW'(1);
                        state_d = S_FETCH;
                    end
                    OP_MOV: begin
                        we_c    = 1'b1;
                        wd_c    = a_val;
                        pc_d    = pc_q + PW'(1);
                        state_d = S_FETCH;
                    end
                    OP_MUL: begin
                        prod_d  = prod_full;
                        state_d = S_MUL;
                    end
                    OP_IN: begin
                        in_ready_d = 1'b1;
                        state_d    = S_IN_WAIT;
                    end
                    OP_OUT: begin
                        out_data_d  = a_val;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT_WAIT;
                    end
                    OP_HALT: begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        pc_d    = pc_q + PW'(1);
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MUL: begin
                we_c    = 1'b1;
                wd_c    = mul_res;
                sat_d   = sat_q | mul_ovf;
                pc_d    = pc_q + PW'(1);
                state_d = S_FETCH;
            end
            S_IN_WAIT: begin
                if (in_valid) begin
                    we_c       = 1'b1;
                    wd_c       = in_data;
                    in_ready_d = 1'b0;
                    pc_d       = pc_q + PW'(1);
                    state_d    = S_FETCH;
                end
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_q + PW'(1);
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Register-file writeback: r0 stays zero
    always_comb begin
        rf_d[0] = '0;
        for (int unsigned i = 1; i < NR; i++) begin
            rf_d[i] = (we_c && dst == ADDRW'(i)) ? wd_c : rf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            prod_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            for (int unsigned i = 0; i < NR; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            prod_q      <= prod_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
            for (int unsigned i = 0; i < NR; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Program memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[prog_waddr] <= prog_wdata;
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_flag  = sat_q;
    assign pc_dbg    = pc_q;
endmodule

// File: tb/tb_kf_engine.sv
// Directed self-checking bench for kf_engine: table of two-operand programs plus handshake/reset/timing sequences.
module tb_kf_engine;
    logic        clk = 1'b0;
    logic        rst, start, prog_we;
    logic [5:0]  prog_waddr;
    logic [15:0] prog_wdata;
    logic [23:0] in_data;
    logic        in_valid, in_ready;
    logic [23:0] out_data;
    logic        out_valid, out_ready;
    logic        busy, done, sat_flag;
    logic [5:0]  pc_dbg;

    int passed = 0;
    int total  = 0;

    kf_engine dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .sat_flag(sat_flag), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] exp;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] d,
                                        input logic [3:0] a, input logic [3:0] b);
        return {op, d, a, b};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        $display("FAIL %s: timed out, expected event did not occur", nm);
    endtask

    task automatic load(input int addr, input logic [15:0] w);
        prog_we = 1'b1; prog_waddr = 6'(addr); prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [23:0] d, input string nm);
        int n = 0;
        in_data = d; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) timeout_fail(nm);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) timeout_fail(nm);
    endtask

    task automatic collect(input logic [23:0] exp, input logic do_check, input string nm);
        wait_out(nm);
        if (do_check) check(nm, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 30) begin @(negedge clk); n++; end
        if (!done) timeout_fail(nm);
        else begin
            check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            @(negedge clk);
            check({nm, "_done_once"}, 32'(done), 32'd0);
        end
    endtask

    task automatic load_two_op(input logic [3:0] op);
        load(0, ins(4'd5, 4'd1, 4'd0, 4'd0));
        load(1, ins(4'd5, 4'd2, 4'd0, 4'd0));
        load(2, ins(op,   4'd3, 4'd1, 4'd2));
        load(3, ins(4'd6, 4'd0, 4'd3, 4'd0));
        load(4, ins(4'd7, 4'd0, 4'd0, 4'd0));
    endtask

    logic [23:0] held;
    int cnt, n;
    logic sat_on;

    initial begin
`ifdef KF_SAT_EN
        sat_on = 1'b1;
`else
        sat_on = 1'b0;
`endif
        vecs[0] = '{"mul_2x1p5",   4'd3, 24'h008000, 24'h006000, 24'h00C000, 1'b0};
        vecs[1] = '{"add_ovf_pos", 4'd1, 24'h7FFFFF, 24'h000001, sat_on ? 24'h7FFFFF : 24'h800000, sat_on};
        vecs[2] = '{"sub_neg",     4'd2, 24'h000010, 24'h000030, 24'hFFFFE0, 1'b0};
        vecs[3] = '{"mul_neg",     4'd3, 24'hFFC000, 24'h00A000, 24'hFF6000, 1'b0};
        vecs[4] = '{"sub_ovf_neg", 4'd2, 24'h800000, 24'h000001, sat_on ? 24'h800000 : 24'h7FFFFF, sat_on};
        vecs[5] = '{"mov",         4'd4, 24'h001234, 24'h00ABCD, 24'h001234, 1'b0};
        vecs[6] = '{"mul_ovf",     4'd3, 24'h7FFFFF, 24'h7FFFFF, sat_on ? 24'h7FFFFF : 24'hFFFC00, sat_on};
        vecs[7] = '{"mul_floor",   4'd3, 24'hFFFFFF, 24'h002000, 24'hFFFFFF, 1'b0};
        vecs[8] = '{"add_ovf_2",   4'd1, 24'h400000, 24'h400000, sat_on ? 24'h7FFFFF : 24'h800000, sat_on};

        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_waddr = '0; prog_wdata = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pc", 32'(pc_dbg), 32'd0);

        // Table: IN r1; IN r2; <op> r3,r1,r2; OUT r3; HALT
        for (int i = 0; i < 9; i++) begin
            load_two_op(vecs[i].op);
            pulse_start();
            check({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
            feed(vecs[i].a, {vecs[i].name, "_in_a"});
            feed(vecs[i].b, {vecs[i].name, "_in_b"});
            collect(vecs[i].exp, 1'b1, {vecs[i].name, "_out"});
            wait_done(vecs[i].name);
            check({vecs[i].name, "_sat"}, 32'(sat_flag), 32'(vecs[i].exp_sat));
        end

        // Output stall: out_valid/out_data/pc hold while out_ready is low
        load_two_op(4'd1);
        pulse_start();
        feed(24'h000100, "stall_in_a");
        feed(24'h000023, "stall_in_b");
        wait_out("stall_wait");
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h000123);
            check("stall_pc", 32'(pc_dbg), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_valid_drop", 32'(out_valid), 32'd0);
        check("stall_pc_next", 32'(pc_dbg), 32'd4);
        wait_done("stall");

        // Writes to r0 are discarded
        load(0, ins(4'd5, 4'd1, 4'd0, 4'd0));
        load(1, ins(4'd4, 4'd0, 4'd1, 4'd0));
        load(2, ins(4'd6, 4'd0, 4'd0, 4'd0));
        load(3, ins(4'd7, 4'd0, 4'd0, 4'd0));
        pulse_start();
        feed(24'h001234, "r0_in");
        collect(24'h000000, 1'b1, "r0_out");
        wait_done("r0");

        // Reset during IN_WAIT, then rerun: OUT r3; IN r1; IN r2; ADD r3,r1,r2; OUT r3; HALT
        load(0, ins(4'd6, 4'd0, 4'd3, 4'd0));
        load(1, ins(4'd5, 4'd1, 4'd0, 4'd0));
        load(2, ins(4'd5, 4'd2, 4'd0, 4'd0));
        load(3, ins(4'd1, 4'd3, 4'd1, 4'd2));
        load(4, ins(4'd6, 4'd0, 4'd3, 4'd0));
        load(5, ins(4'd7, 4'd0, 4'd0, 4'd0));
        pulse_start();
        collect(24'h0, 1'b0, "rr_pre_out");
        feed(24'h000555, "rr_pre_in");
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) timeout_fail("rr_wait_in");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd0);
        check("rr_pc", 32'(pc_dbg), 32'd0);
        check("rr_out_data", 32'(out_data), 32'd0);
        pulse_start();
        collect(24'h000000, 1'b1, "rr_r3_cleared");
        feed(24'h000100, "rr_in_a");
        feed(24'h000200, "rr_in_b");
        collect(24'h000300, 1'b1, "rr_sum");
        wait_done("rr");

        // Timing: 3 ADDs + HALT keep busy for 8 cycles; start/prog_we while busy are ignored
        load(0, ins(4'd1, 4'd1, 4'd1, 4'd2));
        load(1, ins(4'd1, 4'd1, 4'd1, 4'd2));
        load(2, ins(4'd1, 4'd1, 4'd1, 4'd2));
        load(3, ins(4'd7, 4'd0, 4'd0, 4'd0));
        for (int run = 0; run < 2; run++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cnt = 0; n = 0;
            while (busy && n < 40) begin
                cnt++;
                if (run == 0 && cnt == 3) begin
                    start = 1'b1; prog_we = 1'b1; prog_waddr = 6'd2;
                    prog_wdata = ins(4'd7, 4'd0, 4'd0, 4'd0);
                end else begin
                    start = 1'b0; prog_we = 1'b0;
                end
                @(negedge clk);
                n++;
            end
            start = 1'b0; prog_we = 1'b0;
            check(run == 0 ? "busy_cycles_ignored" : "busy_cycles_mem_intact", 32'(cnt), 32'd8);
            check("timing_done", 32'(done), 32'd1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
